// File: rtl/input_arbiter.sv
// input_arbiter: grants left/right/space ownership to debounced buttons or keyboard.
// Ports:
//    clk                         clk100 domain clock
//    rst                         asynchronous active-low reset
//    btn_left/right/space        raw asynchronous board buttons
//    kbd_left/right/space        clean keyboard levels, synchronous to clk
//    jump_busy                   character charging/airborne; keeps the grant alive
//    key_left/right/space        arbitrated, registered key levels
//    owner                       registered grant: 00 none, 01 buttons, 10 keyboard
module input_arbiter #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int RELEASE_CYCLES  = 65_536
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_space,
   input  logic       kbd_left,
   input  logic       kbd_right,
   input  logic       kbd_space,
   input  logic       jump_busy,
   output logic       key_left,
   output logic       key_right,
   output logic       key_space,
   output logic [1:0] owner
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int RW = $clog2(RELEASE_CYCLES);
   typedef enum logic [1:0] {IDLE = 2'b00, BTN = 2'b01, KBD = 2'b10} state_t;
   logic [2:0] btn_raw, deb, kbd, src;
   assign btn_raw = {btn_space, btn_right, btn_left};
   assign kbd     = {kbd_space, kbd_right, kbd_left};
   for (genvar b = 0; b < 3; b++) begin : g_db
      logic meta_q, sync_q, prev_q, deb_q, inc, hit;
      logic [DW-1:0] cnt_q, cnt_d;
      // Count only while the synchronized value differs from the debounced one and did not just move.
      assign inc   = (sync_q != deb_q) && (sync_q == prev_q);
      // Toggle on the cycle the count reaches DEBOUNCE_CYCLES-1.
      assign hit   = inc && cnt_q == DW'(DEBOUNCE_CYCLES - 2);
      assign cnt_d = (!inc || hit) ? '0 : cnt_q == DW'(DEBOUNCE_CYCLES - 1) ? cnt_q : cnt_q + DW'(1);
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            {meta_q, sync_q, prev_q, deb_q} <= '0;
            cnt_q <= '0;
         end else begin
            meta_q <= btn_raw[b];
            sync_q <= meta_q;
            prev_q <= sync_q;
            deb_q  <= deb_q ^ hit;
            cnt_q  <= cnt_d;
         end
      end
      assign deb[b] = deb_q;
   end
   state_t        state_q, state_d;
   logic [RW-1:0] rel_q, rel_d;
   logic          btn_act, kbd_act, quiet, rel_hit, conflict;
   always_comb begin
      btn_act  = |deb;
      kbd_act  = |kbd;
      quiet    = !(state_q == BTN ? btn_act : kbd_act) && !jump_busy;
      rel_hit  = quiet && rel_q == RW'(RELEASE_CYCLES - 1);
      state_d  = state_q == IDLE ? (btn_act ? BTN : kbd_act ? KBD : IDLE) : rel_hit ? IDLE : state_q;
      rel_d    = (state_q == IDLE || !quiet || rel_hit) ? '0 : rel_q + RW'(1);
      // Outputs follow the next owner so the granting cycle already carries its values.
      src      = state_d == BTN ? deb : state_d == KBD ? kbd : 3'b000;
      conflict = src[0] & src[1];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rel_q   <= '0;
         {key_space, key_right, key_left} <= '0;
      end else begin
         state_q   <= state_d;
         rel_q     <= rel_d;
         key_left  <= src[0] & ~conflict;
         key_right <= src[1] & ~conflict;
         key_space <= src[2];
      end
   end
   assign owner = state_q;
endmodule

// File: tb/tb_input_arbiter.sv
// tb_input_arbiter: randomized and directed checks of input_arbiter against a behavioural model.
module tb_input_arbiter;
   localparam int D = 4;
   localparam int R = 8;
   logic clk = 0, rst = 1;
   logic btn_left = 0, btn_right = 0, btn_space = 0;
   logic kbd_left = 0, kbd_right = 0, kbd_space = 0, jump_busy = 0;
   logic key_left, key_right, key_space;
   logic [1:0] owner;
   logic [2:0] keys;
   int n_checks = 0, n_errors = 0;
   logic [2:0] m_raw1, m_sync, m_deb, m_keys;
   int m_run[3];
   int m_state, m_quiet;
   assign keys = {key_space, key_right, key_left};
   input_arbiter #(.DEBOUNCE_CYCLES(D), .RELEASE_CYCLES(R)) dut (
      .clk(clk), .rst(rst),
      .btn_left(btn_left), .btn_right(btn_right), .btn_space(btn_space),
      .kbd_left(kbd_left), .kbd_right(kbd_right), .kbd_space(kbd_space),
      .jump_busy(jump_busy),
      .key_left(key_left), .key_right(key_right), .key_space(key_space),
      .owner(owner)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_raw1 = '0; m_sync = '0; m_deb = '0; m_keys = '0;
      m_run = '{1, 1, 1};
      m_state = 0; m_quiet = 0;
   endtask
   // One clock: the model sees the same pre-edge inputs as the DUT, then both are compared.
   task automatic step();
      logic [2:0] raw, kb, src;
      logic jb, b_act, k_act, own_act;
      raw = {btn_space, btn_right, btn_left};
      kb  = {kbd_space, kbd_right, kbd_left};
      jb  = jump_busy;
      @(posedge clk);
      b_act = |m_deb;
      k_act = |kb;
      if (m_state == 0) begin
         m_state = b_act ? 1 : k_act ? 2 : 0;
         m_quiet = 0;
      end else begin
         own_act = (m_state == 1) ? b_act : k_act;
         m_quiet = (own_act || jb) ? 0 : m_quiet + 1;
         if (m_quiet == R) begin
            m_state = 0;
            m_quiet = 0;
         end
      end
      src = (m_state == 1) ? m_deb : (m_state == 2) ? kb : 3'b000;
      m_keys = (src[0] && src[1]) ? {src[2], 2'b00} : src;
      for (int b = 0; b < 3; b++) begin
         if (m_sync[b] != m_deb[b] && m_run[b] >= D) m_deb[b] = ~m_deb[b];
         m_run[b] = (m_raw1[b] == m_sync[b]) ? m_run[b] + 1 : 1;
         m_sync[b] = m_raw1[b];
         m_raw1[b] = raw[b];
      end
      #1;
      check("owner", owner, m_state);
      check("keys", keys, m_keys);
   endtask
   initial begin
      model_reset();
      #2 rst = 0;
      #20;
      check("rst_owner", owner, 0);
      check("rst_keys", keys, 0);
      @(negedge clk);
      rst = 1;
      // Keyboard grant and release timing
      kbd_space = 1; step();
      check("kbd_grant_owner", owner, 2);
      check("kbd_grant_space", key_space, 1);
      repeat (3) step();
      kbd_space = 0; step();
      check("kbd_drop_space", key_space, 0);
      repeat (6) step();
      check("kbd_hold_owner", owner, 2);
      step();
      check("kbd_release_owner", owner, 0);
      // Short button glitch is filtered, long press gets through with fixed latency
      btn_right = 1; repeat (3) step();
      btn_right = 0;
      repeat (12) begin
         step();
         check("pulse_right", keys, 0);
      end
      btn_right = 1; repeat (6) step();
      check("btn_early", key_right, 0);
      step();
      check("btn_right_lat", key_right, 1);
      check("btn_owner", owner, 1);
      repeat (13) step();
      btn_right = 0; repeat (25) step();
      check("btn_release", owner, 0);
      // Simultaneous requests: buttons win, keyboard then ignored
      btn_left = 1; repeat (6) step();
      kbd_left = 1; step();
      check("tie_owner", owner, 1);
      check("tie_left", key_left, 1);
      for (int i = 0; i < 8; i++) begin
         kbd_right = i[0];
         step();
         check("btn_ignores_kbd", key_right, 0);
      end
      btn_left = 0; kbd_left = 0; kbd_right = 0;
      repeat (25) step();
      check("tie_release", owner, 0);
      // jump_busy holds a keyboard grant; pending button wins after release
      kbd_left = 1; step();
      check("kbd2_owner", owner, 2);
      kbd_left = 0; jump_busy = 1; btn_space = 1;
      repeat (30) step();
      check("busy_hold", owner, 2);
      jump_busy = 0; repeat (7) step();
      check("busy_pre", owner, 2);
      step();
      check("busy_release", owner, 0);
      step();
      check("pending_btn", owner, 1);
      check("pending_space", key_space, 1);
      btn_space = 0; repeat (25) step();
      check("pending_done", owner, 0);
      // Left+right conflict suppression
      kbd_left = 1; kbd_right = 1; kbd_space = 1; step();
      check("conf_keys", keys, 3'b100);
      check("conf_owner", owner, 2);
      // Asynchronous reset between edges, then debounce restarts
      #3 rst = 0;
      #1;
      check("async_keys", keys, 0);
      check("async_owner", owner, 0);
      model_reset();
      kbd_left = 0; kbd_right = 0; kbd_space = 0; btn_left = 1;
      #1 rst = 1;
      repeat (6) step();
      check("rst_deb_early", key_left, 0);
      step();
      check("rst_deb_lat", key_left, 1);
      btn_left = 0; repeat (25) step();
      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(7) == 0) btn_left  = ~btn_left;
         if ($urandom_range(7) == 0) btn_right = ~btn_right;
         if ($urandom_range(7) == 0) btn_space = ~btn_space;
         if ($urandom_range(5) == 0) kbd_left  = ($urandom_range(3) == 0);
         if ($urandom_range(5) == 0) kbd_right = ($urandom_range(3) == 0);
         if ($urandom_range(5) == 0) kbd_space = ($urandom_range(3) == 0);
         if ($urandom_range(9) == 0) jump_busy = ~jump_busy;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
